regs_wb_arbiter: RTL and testbench
==================================

Name: regs_wb_arbiter

Overview:
- Write-port arbiter and sequencer for the 31x32 register file, which has a single write port (L_S, Wt_addr, Wt_data).
- Shares that port between two writeback requesters: ALU writeback and memory-load writeback.
- Each requester has its own one-entry holding slot.
- Arbitration is age-ordered for same-address writes and round-robin otherwise.
- Exports a pending-write mask for the hazard unit.

Parameters:
- DW, 32, data width of a writeback.
- AW, 5, register address width; the register file has 2^AW entries, and entry 0 is hardwired to zero.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- alu_valid  input  1  ALU writeback request.
- alu_ready  output  1  ALU slot can accept this cycle.
- alu_addr  input  AW  ALU destination register.
- alu_data  input  DW  ALU result.
- mem_valid  input  1  load writeback request.
- mem_ready  output  1  MEM slot can accept this cycle.
- mem_addr  input  AW  load destination register.
- mem_data  input  DW  load data.
- L_S  output  1  write enable to the register file.
- Wt_addr  output  AW  write address to the register file.
- Wt_data  output  DW  write data to the register file.
- pend_mask  output  2^AW  bit i = 1 while a held write targets register i; bit 0 is always 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - Both slots empty; age bit cleared; round-robin pointer set to ALU.
  - Outputs: L_S=0, Wt_addr=0, Wt_data=0, pend_mask=0.
  - alu_ready=mem_ready=0 while rst=0; both become 1 on the first cycle after release.
  - A reset mid-operation discards held writes; they are never issued.
- Capture: a request is accepted on the rising edge where valid && ready.
  - A request with addr 0 is accepted and dropped; no slot is filled and no write is issued.
- Slot state per requester: EMPTY -> FULL on capture; FULL -> EMPTY on grant.
  - FULL -> FULL when grant and a new capture occur on the same edge (back-to-back).
- ready = slot EMPTY, or slot FULL and granted this cycle (combinational).
- Grant (combinational, every cycle):
  - Neither slot FULL: no grant. L_S=0; Wt_addr and Wt_data driven to 0.
  - One slot FULL: that slot is granted.
  - Both FULL, different addresses: grant follows the round-robin pointer; the pointer then moves to the other requester.
  - Both FULL, same address: the older entry (per the age bit) is granted first, so the younger value is what remains in the register. The pointer is unaffected.
- Age bit:
  - Records which slot was captured first.
  - Simultaneous capture into both empty slots: ALU is older.
  - Capturing into one slot while the other is FULL makes the new entry younger.
- Port drive: L_S=1 and Wt_addr/Wt_data are driven from the granted slot in the same cycle. The register file commits on the following rising edge.
- Latency: a request accepted at edge N is written at edge N+1 if uncontended, or N+2 if it loses arbitration once.
  - Worst case is N+2; no starvation.
- pend_mask:
  - Decoded combinationally from the FULL slots.
  - Bit i clears in the same edge that commits the write to register i, unless the other slot also holds i.
- Throughput: one register-file write per cycle maximum.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined: adds ports fwd_addr_A (AW, input), fwd_addr_B (AW, input), fwd_hit_A (1, output), fwd_hit_B (1, output), fwd_data_A (DW, output), fwd_data_B (DW, output).
  - A hit is raised when a FULL slot holds the probed address and that address is nonzero.
  - Data comes from the youngest matching slot.
  - Combinational. Reset value: hit=0, data=0.
- Undefined: these ports are absent; consumers stall on pend_mask only.

Test Plan:
- Reset: rst=0 with both slots loaded, release -> L_S=0, pend_mask=0, both readies=1, no write issued.
- Single write: alu_valid=1, alu_addr=3, alu_data=0x1234 accepted at edge 1 -> L_S=1, Wt_addr=3, Wt_data=0x1234 in cycle 2; pend_mask=0x8 in cycle 2, 0 after edge 2.
- Contention, different addresses: ALU (r5, 0xA) and MEM (r6, 0xB) accepted on the same edge, pointer=ALU -> r5 written first, then r6; next simultaneous pair is MEM first.
- Same-address ordering: MEM (r7, 0x11) accepted one cycle before ALU (r7, 0x22) while the MEM slot is still held -> writes in order 0x11 then 0x22; final r7=0x22.
- Register 0: mem_valid, mem_addr=0, mem_data=0xFF -> accepted (mem_ready=1), L_S stays 0, pend_mask stays 0.
- Back-to-back with WB_FWD_EN: alu_valid held 4 cycles with r9..r12 -> one write per cycle, alu_ready held 1. fwd_addr_A=10 while r10 is held -> fwd_hit_A=1 with that data.

Source files
------------

// File: rtl/regs_wb_arbiter.sv
// Write-port arbiter for the register file: two one-entry writeback slots (ALU, MEM), age/round-robin grant.
// Optional forwarding probes are compiled in when WB_FWD_EN is defined.
module regs_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [AW-1:0]       alu_addr,
    input  logic [DW-1:0]       alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [AW-1:0]       mem_addr,
    input  logic [DW-1:0]       mem_data,
`ifdef WB_FWD_EN
    input  logic [AW-1:0]       fwd_addr_A,
    input  logic [AW-1:0]       fwd_addr_B,
    output logic                fwd_hit_A,
    output logic                fwd_hit_B,
    output logic [DW-1:0]       fwd_data_A,
    output logic [DW-1:0]       fwd_data_B,
`endif
    output logic                L_S,
    output logic [AW-1:0]       Wt_addr,
    output logic [DW-1:0]       Wt_data,
    output logic [(1<<AW)-1:0]  pend_mask
);

    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_e;
    typedef enum logic {SEL_ALU, SEL_MEM} sel_e;

    slot_e          alu_st_q, alu_st_d;
    slot_e          mem_st_q, mem_st_d;
    logic [AW-1:0]  alu_addr_q, alu_addr_d;
    logic [AW-1:0]  mem_addr_q, mem_addr_d;
    logic [DW-1:0]  alu_data_q, alu_data_d;
    logic [DW-1:0]  mem_data_q, mem_data_d;
    sel_e           older_q, older_d;
    sel_e           rr_q, rr_d;

    logic alu_full, mem_full, same_addr;
    logic gnt_alu, gnt_mem;
    logic cap_alu, cap_mem;
    logic hold_alu, hold_mem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_st_q   <= SLOT_EMPTY;
            mem_st_q   <= SLOT_EMPTY;
            alu_addr_q <= '0;
            mem_addr_q <= '0;
            alu_data_q <= '0;
            mem_data_q <= '0;
            older_q    <= SEL_ALU;
            rr_q       <= SEL_ALU;
        end else begin
            alu_st_q   <= alu_st_d;
            mem_st_q   <= mem_st_d;
            alu_addr_q <= alu_addr_d;
            mem_addr_q <= mem_addr_d;
            alu_data_q <= alu_data_d;
            mem_data_q <= mem_data_d;
            older_q    <= older_d;
            rr_q       <= rr_d;
        end
    end

    // Same-address pairs go oldest-first so the younger value lands last.
    always_comb begin
        alu_full  = (alu_st_q == SLOT_FULL);
        mem_full  = (mem_st_q == SLOT_FULL);
        same_addr = (alu_addr_q == mem_addr_q);
        gnt_alu   = 1'b0;
        gnt_mem   = 1'b0;
        if (alu_full && mem_full) begin
            if (same_addr) begin
                gnt_alu = (older_q == SEL_ALU);
                gnt_mem = (older_q == SEL_MEM);
            end else begin
                gnt_alu = (rr_q == SEL_ALU);
                gnt_mem = (rr_q == SEL_MEM);
            end
        end else begin
            gnt_alu = alu_full;
            gnt_mem = mem_full;
        end
    end

    always_comb begin
        alu_ready = rst && (!alu_full || gnt_alu);
        mem_ready = rst && (!mem_full || gnt_mem);
        cap_alu   = alu_valid && alu_ready && (alu_addr != '0);
        cap_mem   = mem_valid && mem_ready && (mem_addr != '0);
        hold_alu  = alu_full && !gnt_alu;
        hold_mem  = mem_full && !gnt_mem;
    end

    always_comb begin
        alu_st_d   = alu_st_q;
        alu_addr_d = alu_addr_q;
        alu_data_d = alu_data_q;
        case (alu_st_q)
            SLOT_EMPTY: if (cap_alu) alu_st_d = SLOT_FULL;
            SLOT_FULL:  if (gnt_alu && !cap_alu) alu_st_d = SLOT_EMPTY;
            default:    alu_st_d = SLOT_EMPTY;
        endcase
        if (cap_alu) begin
            alu_addr_d = alu_addr;
            alu_data_d = alu_data;
        end
    end

    always_comb begin
        mem_st_d   = mem_st_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        case (mem_st_q)
            SLOT_EMPTY: if (cap_mem) mem_st_d = SLOT_FULL;
            SLOT_FULL:  if (gnt_mem && !cap_mem) mem_st_d = SLOT_EMPTY;
            default:    mem_st_d = SLOT_EMPTY;
        endcase
        if (cap_mem) begin
            mem_addr_d = mem_addr;
            mem_data_d = mem_data;
        end
    end

    // Age only matters while both slots hold; a capture beside a held entry is the younger one.
    always_comb begin
        older_d = older_q;
        if (cap_alu && cap_mem)
            older_d = SEL_ALU;
        else if (cap_alu && hold_mem)
            older_d = SEL_MEM;
        else if (cap_mem && hold_alu)
            older_d = SEL_ALU;

        rr_d = rr_q;
        if (alu_full && mem_full && !same_addr)
            rr_d = gnt_alu ? SEL_MEM : SEL_ALU;
    end

    always_comb begin
        L_S     = gnt_alu || gnt_mem;
        Wt_addr = '0;
        Wt_data = '0;
        if (gnt_alu) begin
            Wt_addr = alu_addr_q;
            Wt_data = alu_data_q;
        end else if (gnt_mem) begin
            Wt_addr = mem_addr_q;
            Wt_data = mem_data_q;
        end
    end

    always_comb begin
        pend_mask = '0;
        if (alu_full) pend_mask[alu_addr_q] = 1'b1;
        if (mem_full) pend_mask[mem_addr_q] = 1'b1;
        pend_mask[0] = 1'b0;
    end

`ifdef WB_FWD_EN
    function automatic logic [DW:0] fwd_lookup(input logic [AW-1:0] a);
        logic ah, mh;
        logic [DW-1:0] d;
        ah = alu_full && (alu_addr_q == a) && (a != '0);
        mh = mem_full && (mem_addr_q == a) && (a != '0);
        d  = '0;
        if (ah && mh)
            d = (older_q == SEL_ALU) ? mem_data_q : alu_data_q;
        else if (ah)
            d = alu_data_q;
        else if (mh)
            d = mem_data_q;
        return {ah || mh, d};
    endfunction

    always_comb begin
        {fwd_hit_A, fwd_data_A} = fwd_lookup(fwd_addr_A);
        {fwd_hit_B, fwd_data_B} = fwd_lookup(fwd_addr_B);
    end
`endif

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Directed bench for regs_wb_arbiter; forwarding checks are compiled in with WB_FWD_EN.
module tb_regs_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, mem_valid;
    logic          alu_ready, mem_ready;
    logic [AW-1:0] alu_addr, mem_addr;
    logic [DW-1:0] alu_data, mem_data;
    logic          L_S;
    logic [AW-1:0] Wt_addr;
    logic [DW-1:0] Wt_data;
    logic [31:0]   pend_mask;
`ifdef WB_FWD_EN
    logic [AW-1:0] fwd_addr_A, fwd_addr_B;
    logic          fwd_hit_A, fwd_hit_B;
    logic [DW-1:0] fwd_data_A, fwd_data_B;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;
    logic [DW-1:0] rf [32] = '{default: '0};

    regs_wb_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
`ifdef WB_FWD_EN
        .fwd_addr_A(fwd_addr_A), .fwd_addr_B(fwd_addr_B),
        .fwd_hit_A(fwd_hit_A), .fwd_hit_B(fwd_hit_B),
        .fwd_data_A(fwd_data_A), .fwd_data_B(fwd_data_B),
`endif
        .L_S(L_S), .Wt_addr(Wt_addr), .Wt_data(Wt_data), .pend_mask(pend_mask)
    );

    always #5 clk = ~clk;

    // Register-file stand-in: commits on the edge after the port is driven.
    always @(posedge clk) begin
        if (L_S) begin
            rf[Wt_addr] <= Wt_data;
            n_writes    <= n_writes + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
        check_eq({tag, "_ls"}, 64'(L_S), 64'd1);
        check_eq({tag, "_addr"}, 64'(Wt_addr), 64'(a));
        check_eq({tag, "_data"}, 64'(Wt_data), 64'(d));
    endtask

    initial begin
        rst = 1'b0;
        alu_valid = 1'b0; mem_valid = 1'b0;
        alu_addr = '0; mem_addr = '0; alu_data = '0; mem_data = '0;
`ifdef WB_FWD_EN
        fwd_addr_A = '0; fwd_addr_B = '0;
`endif
        tick(); tick();
        check_eq("rst_ls", 64'(L_S), 64'd0);
        check_eq("rst_addr", 64'(Wt_addr), 64'd0);
        check_eq("rst_data", 64'(Wt_data), 64'd0);
        check_eq("rst_pend", 64'(pend_mask), 64'd0);
        check_eq("rst_alu_rdy", 64'(alu_ready), 64'd0);
        check_eq("rst_mem_rdy", 64'(mem_ready), 64'd0);
`ifdef WB_FWD_EN
        check_eq("rst_fwd_hit", 64'({fwd_hit_A, fwd_hit_B}), 64'd0);
        check_eq("rst_fwd_data", 64'(fwd_data_A | fwd_data_B), 64'd0);
`endif
        rst = 1'b1;
        #1;
        check_eq("rel_alu_rdy", 64'(alu_ready), 64'd1);
        check_eq("rel_mem_rdy", 64'(mem_ready), 64'd1);

        // Load both slots, then reset before anything commits.
        tick();
        alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h55;
        mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 32'h66;
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        #1;
        expect_write("preload", 5'd1, 32'h55);
        check_eq("preload_pend", 64'(pend_mask), 64'h6);
        rst = 1'b0;
        #1;
        check_eq("midrst_ls", 64'(L_S), 64'd0);
        check_eq("midrst_pend", 64'(pend_mask), 64'd0);
        check_eq("midrst_rdy", 64'({alu_ready, mem_ready}), 64'd0);
        tick(); tick();
        rst = 1'b1;
        #1;
        check_eq("post_rdy", 64'({alu_ready, mem_ready}), 64'h3);
        check_eq("post_ls", 64'(L_S), 64'd0);
        tick();
        check_eq("post_ls2", 64'(L_S), 64'd0);
        check_eq("post_nwr", 64'(n_writes), 64'd0);
        check_eq("post_rf1", 64'(rf[1]), 64'd0);

        // Single uncontended write.
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h1234;
        #1;
        check_eq("single_rdy", 64'(alu_ready), 64'd1);
        tick();
        alu_valid = 1'b0;
        #1;
        expect_write("single", 5'd3, 32'h1234);
        check_eq("single_pend", 64'(pend_mask), 64'h8);
        tick();
        check_eq("single_idle", 64'(L_S), 64'd0);
        check_eq("single_pend0", 64'(pend_mask), 64'd0);
        check_eq("single_rf3", 64'(rf[3]), 64'h1234);

        // Contention, different addresses: pointer at ALU, then MEM.
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hA;
        mem_valid = 1'b1; mem_addr = 5'd6; mem_data = 32'hB;
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        #1;
        expect_write("cont1a", 5'd5, 32'hA);
        check_eq("cont1a_pend", 64'(pend_mask), 64'h60);
        check_eq("cont1a_rdy", 64'({alu_ready, mem_ready}), 64'h2);
        tick();
        expect_write("cont1b", 5'd6, 32'hB);
        check_eq("cont1b_pend", 64'(pend_mask), 64'h40);
        tick();
        check_eq("cont1_idle", 64'(L_S), 64'd0);
        alu_valid = 1'b1; alu_addr = 5'd8; alu_data = 32'hC;
        mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 32'hD;
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        #1;
        expect_write("cont2a", 5'd9, 32'hD);
        tick();
        expect_write("cont2b", 5'd8, 32'hC);
        tick();

        // Same-address ordering: MEM r7 held behind ALU r4, then ALU r7 captured.
        alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h44;
        mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h11;
        tick();
        mem_valid = 1'b0;
        alu_addr = 5'd7; alu_data = 32'h22;
        #1;
        expect_write("same_r4", 5'd4, 32'h44);
        check_eq("same_alu_rdy", 64'(alu_ready), 64'd1);
        tick();
        alu_valid = 1'b0;
        #1;
        expect_write("same_old", 5'd7, 32'h11);
        check_eq("same_pend", 64'(pend_mask), 64'h80);
        tick();
        expect_write("same_young", 5'd7, 32'h22);
        check_eq("same_pend2", 64'(pend_mask), 64'h80);
        tick();
        check_eq("same_pend3", 64'(pend_mask), 64'd0);
        check_eq("same_rf7", 64'(rf[7]), 64'h22);

        // Register 0 write is accepted and dropped.
        mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'hFF;
        #1;
        check_eq("r0_rdy", 64'(mem_ready), 64'd1);
        tick();
        mem_valid = 1'b0;
        #1;
        check_eq("r0_ls", 64'(L_S), 64'd0);
        check_eq("r0_pend", 64'(pend_mask), 64'd0);
        tick();
        check_eq("r0_ls2", 64'(L_S), 64'd0);

        // Back-to-back ALU writes r9..r12.
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1;
            alu_addr  = AW'(9 + i);
            alu_data  = 32'h900 + 32'(9 + i);
            #1;
            check_eq($sformatf("b2b_rdy%0d", i), 64'(alu_ready), 64'd1);
            if (i > 0) begin
                expect_write($sformatf("b2b%0d", i), AW'(8 + i), 32'h900 + 32'(8 + i));
`ifdef WB_FWD_EN
                fwd_addr_A = 5'd10; fwd_addr_B = 5'd3;
                #1;
                check_eq($sformatf("fwdA_hit%0d", i), 64'(fwd_hit_A), 64'(i == 2));
                check_eq($sformatf("fwdA_data%0d", i), 64'(fwd_data_A), (i == 2) ? 64'h90A : 64'd0);
                check_eq($sformatf("fwdB_hit%0d", i), 64'(fwd_hit_B), 64'd0);
`endif
            end
            tick();
        end
        alu_valid = 1'b0;
        #1;
        expect_write("b2b4", 5'd12, 32'h90C);
        tick();
        check_eq("b2b_idle", 64'(L_S), 64'd0);
        check_eq("b2b_rf12", 64'(rf[12]), 64'h90C);
        check_eq("total_writes", 64'(n_writes), 64'd12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
